// File: rtl/jpc_ifetch_pkg.sv
// Shared types and constants for the jpc instruction fetch unit.
// State encoding, reset PC default and the alignment helper.
package jpc_ifetch_pkg;

  localparam int STATE_W = 2;
  localparam logic [31:0] JPC_RESET_PC = 32'h0000_0000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } ifetch_state_e;

  function automatic logic word_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/jpc_ifetch.sv
// Instruction fetch: holds the PC, fetches words from imem and
// presents them to decode over a valid/ready handshake.
import jpc_ifetch_pkg::*;

module jpc_ifetch #(
  parameter logic [31:0] RESET_PC = JPC_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_I,
  input  logic        pc_load_I,
  input  logic [31:0] pc_load_val_I,
  output logic        imem_req_O,
  output logic [31:0] imem_addr_O,
  input  logic        imem_ack_I,
  input  logic [31:0] imem_rdata_I,
  input  logic        imem_err_I,
  output logic [31:0] instr_O,
  output logic [31:0] pc_O,
  output logic        instr_valid_O,
  input  logic        instr_ready_I,
  output logic        fetch_err_O
);

  ifetch_state_e state;
  logic [31:0]   pc;
  logic          discard;

  logic [31:0] pc_nxt;
  logic        ack_now;
  logic        req_hold;
  logic        load_ok;

  assign pc_nxt   = pc + 32'd4;
  assign ack_now  = imem_req_O & imem_ack_I;
  assign req_hold = imem_req_O & ~imem_ack_I;
  assign load_ok  = word_aligned(pc_load_val_I);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      imem_req_O    <= 1'b0;
      imem_addr_O   <= 32'd0;
      instr_O       <= 32'd0;
      pc_O          <= 32'd0;
      instr_valid_O <= 1'b0;
      fetch_err_O   <= 1'b0;
    end else if (pc_load_I) begin
      // an in-flight request cannot be withdrawn; mark its reply stale
      if (ack_now) begin
        imem_req_O <= 1'b0;
        discard    <= 1'b0;
      end else if (imem_req_O) begin
        discard <= 1'b1;
      end
      instr_valid_O <= 1'b0;
      if (!load_ok) begin
        state       <= S_ERR;
        fetch_err_O <= 1'b1;
      end else begin
        pc          <= pc_load_val_I;
        fetch_err_O <= 1'b0;
        state       <= req_hold ? S_REQ : S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en_I) begin
            imem_req_O  <= 1'b1;
            imem_addr_O <= pc;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack_I) begin
            imem_req_O <= 1'b0;
            discard    <= 1'b0;
            if (discard) begin
              state <= S_IDLE;
            end else if (imem_err_I) begin
              state       <= S_ERR;
              fetch_err_O <= 1'b1;
            end else begin
              state         <= S_VALID;
              instr_valid_O <= 1'b1;
              instr_O       <= imem_rdata_I;
              pc_O          <= pc;
            end
          end
        end
        S_VALID: begin
          if (instr_ready_I) begin
            instr_valid_O <= 1'b0;
            pc            <= pc_nxt;
            if (fetch_en_I) begin
              imem_req_O  <= 1'b1;
              imem_addr_O <= pc_nxt;
              state       <= S_REQ;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          if (ack_now) begin
            imem_req_O <= 1'b0;
            discard    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpc_ifetch.sv
// Bench for jpc_ifetch: directed scenarios then random traffic
// scored against a transaction-level PC/error model.
module tb_jpc_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, pc_load, imem_ack, imem_err, instr_ready;
  logic [31:0] pc_load_val, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, instr, pc_o;
  logic        instr_valid, fetch_err;

  logic        w_en, w_load, w_ack, w_err, w_ready;
  logic [31:0] w_load_val, w_rdata;
  logic        w_req, w_valid, w_ferr;
  logic [31:0] w_addr, w_instr, w_pc;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc;
  logic        exp_err;
  logic        pend, pend_disc, mem_err;
  logic [31:0] pend_addr;
  int          wait_c, lat, xfers;

  always #5 clk = ~clk;

  jpc_ifetch dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_en_I(fetch_en), .pc_load_I(pc_load),
    .pc_load_val_I(pc_load_val),
    .imem_req_O(imem_req), .imem_addr_O(imem_addr),
    .imem_ack_I(imem_ack), .imem_rdata_I(imem_rdata),
    .imem_err_I(imem_err),
    .instr_O(instr), .pc_O(pc_o),
    .instr_valid_O(instr_valid), .instr_ready_I(instr_ready),
    .fetch_err_O(fetch_err)
  );

  jpc_ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .fetch_en_I(w_en), .pc_load_I(w_load),
    .pc_load_val_I(w_load_val),
    .imem_req_O(w_req), .imem_addr_O(w_addr),
    .imem_ack_I(w_ack), .imem_rdata_I(w_rdata),
    .imem_err_I(w_err),
    .instr_O(w_instr), .pc_O(w_pc),
    .instr_valid_O(w_valid), .instr_ready_I(w_ready),
    .fetch_err_O(w_ferr)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  // one clock: memory responder, scoreboard, then edge
  task automatic cyc();
    logic xfer;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    imem_err = 1'b0;
    if (imem_req) begin
      if (!pend) begin
        chk("req_addr", imem_addr, exp_pc);
        pend = 1'b1;
        pend_disc = 1'b0;
        pend_addr = imem_addr;
        wait_c = lat;
      end else begin
        chk("addr_stable", imem_addr, pend_addr);
      end
      if (wait_c == 0) begin
        imem_ack = 1'b1;
        imem_rdata = memf(imem_addr);
        imem_err = mem_err;
      end else begin
        wait_c--;
      end
    end
    xfer = instr_valid & instr_ready;
    if (xfer) begin
      chk("xfer_pc", pc_o, exp_pc);
      chk("xfer_instr", instr, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      xfers++;
    end
    if (imem_ack) begin
      pend = 1'b0;
      if (!pc_load && !pend_disc && imem_err) exp_err = 1'b1;
    end
    if (pc_load) begin
      if (imem_req && !imem_ack) pend_disc = 1'b1;
      if (pc_load_val[1:0] != 2'b00) exp_err = 1'b1;
      else begin
        exp_pc = pc_load_val;
        exp_err = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk1("fetch_err", fetch_err, exp_err);
    if (exp_err) chk1("err_novalid", instr_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en = 0; pc_load = 0; pc_load_val = 0;
    imem_ack = 0; imem_rdata = 0; imem_err = 0; instr_ready = 0;
    w_en = 0; w_load = 0; w_load_val = 0; w_ack = 0; w_err = 0;
    w_rdata = 0; w_ready = 0;
    pend = 0; pend_disc = 0; pend_addr = 0; mem_err = 0;
    wait_c = 0; lat = 0; xfers = 0;
    exp_pc = 32'd0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    rst_n = 1'b1;

    // first fetch, 1-cycle ack
    fetch_en = 1;
    cyc();
    chk1("f1_req", imem_req, 1'b1);
    chk("f1_addr", imem_addr, 32'd0);
    cyc();
    chk1("f1_valid", instr_valid, 1'b1);
    chk("f1_instr", instr, 32'h0050_0093);
    chk("f1_pc", pc_o, 32'd0);
    chk1("f1_noreq", imem_req, 1'b0);

    // decoder stalls
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc", pc_o, 32'd0);
      chk1("stall_noreq", imem_req, 1'b0);
    end
    instr_ready = 1;
    cyc();
    chk1("f2_req", imem_req, 1'b1);
    chk("f2_addr", imem_addr, 32'd4);

    // redirect while waiting on a 3-cycle ack
    instr_ready = 0;
    lat = 2;
    pc_load = 1; pc_load_val = 32'h100;
    cyc();
    pc_load = 0;
    chk1("rd_req_held", imem_req, 1'b1);
    chk("rd_addr_held", imem_addr, 32'd4);
    cyc();
    cyc();
    chk1("rd_drop_valid", instr_valid, 1'b0);
    chk1("rd_drop_req", imem_req, 1'b0);
    lat = 0;
    cyc();
    chk("rd_new_addr", imem_addr, 32'h100);

    // bus error at pc=8
    fetch_en = 0; instr_ready = 1;
    cyc();
    cyc();
    chk1("idle_req", imem_req, 1'b0);
    pc_load = 1; pc_load_val = 32'h8;
    cyc();
    pc_load = 0;
    mem_err = 1; fetch_en = 1;
    cyc();
    chk("be_addr", imem_addr, 32'h8);
    cyc();
    mem_err = 0;
    chk1("be_err", fetch_err, 1'b1);
    chk1("be_novalid", instr_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("be_noreq", imem_req, 1'b0);
    end
    pc_load = 1; pc_load_val = 32'h40;
    cyc();
    pc_load = 0;
    chk1("be_clear", fetch_err, 1'b0);
    cyc();
    chk("be_refetch", imem_addr, 32'h40);

    // misaligned redirect
    fetch_en = 0;
    cyc();
    cyc();
    pc_load = 1; pc_load_val = 32'h102;
    cyc();
    pc_load = 0;
    chk1("mis_err", fetch_err, 1'b1);
    chk("mis_pc", pc_o, 32'h40);
    fetch_en = 1;
    cyc();
    cyc();
    chk1("mis_noreq", imem_req, 1'b0);

    // address wrap via redirect
    pc_load = 1; pc_load_val = 32'hFFFF_FFFC;
    cyc();
    pc_load = 0;
    cyc();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wr_pc", pc_o, 32'hFFFF_FFFC);
    cyc();
    chk1("wr_req", imem_req, 1'b1);
    chk("wr_next", imem_addr, 32'h0);
    fetch_en = 0;
    repeat (4) cyc();

    // RESET_PC at top of address space
    w_en = 1;
    cyc();
    chk1("w_req", w_req, 1'b1);
    chk("w_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1; w_rdata = 32'h0050_0093;
    cyc();
    w_ack = 0;
    chk1("w_valid", w_valid, 1'b1);
    chk("w_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_instr", w_instr, 32'h0050_0093);
    w_ready = 1;
    cyc();
    chk1("w_req2", w_req, 1'b1);
    chk("w_wrap", w_addr, 32'h0);
    w_en = 0; w_ready = 0;

    // random traffic
    xfers = 0;
    for (int i = 0; i < 3000; i++) begin
      fetch_en = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      lat = $urandom_range(0, 3);
      mem_err = ($urandom_range(0, 14) == 0);
      pc_load = ($urandom_range(0, 11) == 0);
      pc_load_val = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 4) == 0)
        pc_load_val[1:0] = 2'($urandom_range(1, 3));
      cyc();
    end
    pc_load = 0;
    chk1("rand_progress", xfers > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
